// File: rtl/sipo_jk_rx.sv
// sipo_jk_rx -- serial-in / parallel-out frame receiver.
//
// Collects WIDTH serial bits (MSB first, one per cycle with en=1) into a
// parallel word. The finished word goes to q and raises vld until a consumer
// takes it with rdy. If a frame finishes while the previous word is still
// waiting, the new word is dropped and the sticky ovr flag is set.
//
// Parameters
//   WIDTH  bits per frame / width of q (2..32)
// Ports
//   clk   in   clock, rising edge
//   res   in   synchronous active-low reset
//   sin   in   serial data bit, MSB of each frame first
//   en    in   serial bit strobe; sin is sampled only when en=1
//   sync  in   frame align; drops any partial frame, current bit starts a new one
//   rdy   in   consumer ready; word consumed when vld=1 and rdy=1
//   q     out  parallel word, stable while vld=1
//   vld   out  q holds an unconsumed word
//   busy  out  partial frame in progress (bit count non-zero)
//   ovr   out  sticky overrun flag, cleared only by reset
module sipo_jk_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             sin,
  input  logic             en,
  input  logic             sync,
  input  logic             rdy,
  output logic [WIDTH-1:0] q,
  output logic             vld,
  output logic             busy,
  output logic             ovr
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             frame_done;

  // The incoming bit appended to the bits already shifted in; on the last
  // bit of a frame this is the complete word, first bit at the MSB.
  assign word       = {sr[WIDTH-2:0], sin};
  // sync turns the current bit into the first bit of a new frame, so it
  // can never complete one.
  assign frame_done = en && !sync && (cnt == LAST);
  assign busy       = (cnt != '0);

  // Single register stage: frame assembly and output handshake
  always_ff @(posedge clk) begin
    if (!res) begin
      sr  <= '0;
      cnt <= '0;
      q   <= '0;
      vld <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (en) begin
        sr <= word;
        if (sync)
          cnt <= CW'(1);
        else if (frame_done)
          cnt <= '0;
        else
          cnt <= cnt + CW'(1);
      end else if (sync) begin
        cnt <= '0;
      end

      // A consume in the same cycle frees the slot for the new word.
      if (frame_done) begin
        if (!vld || rdy) begin
          q   <= word;
          vld <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (vld && rdy) begin
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_jk_rx.sv
module tb_sipo_jk_rx;

  localparam int W = 4;

  logic         clk;
  logic         res;
  logic         sin;
  logic         en;
  logic         sync;
  logic         rdy;
  logic [W-1:0] q;
  logic         vld;
  logic         busy;
  logic         ovr;

  int n_assert;
  int n_fail;

  // Reference model: list of bits received in the current frame, plus the
  // word slot, valid and overrun flag.
  bit           m_bits[$];
  logic [W-1:0] m_q;
  logic         m_vld;
  logic         m_ovr;

  sipo_jk_rx #(.WIDTH(W)) dut (
    .clk  (clk),
    .res  (res),
    .sin  (sin),
    .en   (en),
    .sync (sync),
    .rdy  (rdy),
    .q    (q),
    .vld  (vld),
    .busy (busy),
    .ovr  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic s, input logic sy, input logic rd);
    bit           done;
    logic [W-1:0] w;
    done = 1'b0;
    w    = '0;
    if (!r) begin
      m_bits.delete();
      m_q   = '0;
      m_vld = 1'b0;
      m_ovr = 1'b0;
    end else begin
      if (e) begin
        if (sy) begin
          m_bits.delete();
          m_bits.push_back(s);
        end else begin
          m_bits.push_back(s);
          if (m_bits.size() == W) begin
            int acc;
            acc = 0;
            foreach (m_bits[i]) acc = acc * 2 + int'(m_bits[i]);
            w    = W'(acc);
            done = 1'b1;
            m_bits.delete();
          end
        end
      end else if (sy) begin
        m_bits.delete();
      end
      if (done) begin
        if (!m_vld || rd) begin
          m_q   = w;
          m_vld = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_vld && rd) begin
        m_vld = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive on the falling edge, model on the rising edge,
  // compare outputs 1 time unit later.
  task automatic step(input logic r, input logic e, input logic s, input logic sy, input logic rd);
    @(negedge clk);
    res  = r;
    en   = e;
    sin  = s;
    sync = sy;
    rdy  = rd;
    @(posedge clk);
    model_update(r, e, s, sy, rd);
    #1;
    chk("q",    32'(q),    32'(m_q));
    chk("vld",  32'(vld),  32'(m_vld));
    chk("busy", 32'(busy), 32'(m_bits.size() != 0));
    chk("ovr",  32'(ovr),  32'(m_ovr));
  endtask

  task automatic send_frame(input logic [W-1:0] f, input logic rd);
    for (int i = W - 1; i >= 0; i--) step(1'b1, 1'b1, f[i], 1'b0, rd);
  endtask

  task automatic idle(input logic rd);
    step(1'b1, 1'b0, 1'b0, 1'b0, rd);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_q      = '0;
    m_vld    = 1'b0;
    m_ovr    = 1'b0;
    res = 1'b0; en = 1'b0; sin = 1'b0; sync = 1'b0; rdy = 1'b0;

    // Reset state
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_vld_busy_ovr", {29'd0, vld, busy, ovr}, 32'h0);

    // Basic frame 1011, then consume
    send_frame(4'b1011, 1'b0);
    chk("f1011_q", 32'(q), 32'hB);
    chk("f1011_vld", 32'(vld), 32'h1);
    chk("f1011_busy", 32'(busy), 32'h0);
    idle(1'b1);
    chk("consume_vld", 32'(vld), 32'h0);
    chk("consume_q_hold", 32'(q), 32'hB);

    // Gapped strobes: bits 1,1,0,0 with en toggling, sin garbage in gaps
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_busy", 32'(busy), 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_busy2", 32'(busy), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("gap_q", 32'(q), 32'hC);
    chk("gap_vld", 32'(vld), 32'h1);
    idle(1'b1);

    // Overrun: second frame dropped while first waits
    send_frame(4'b0101, 1'b0);
    send_frame(4'b1110, 1'b0);
    chk("ovr_q", 32'(q), 32'h5);
    chk("ovr_set", {30'd0, vld, ovr}, 32'h3);
    idle(1'b1);
    idle(1'b1);
    chk("ovr_sticky", {30'd0, vld, ovr}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_clear", 32'(ovr), 32'h0);

    // Consume in the same cycle as the last bit of the next frame
    send_frame(4'b0011, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("same_cyc_q", 32'(q), 32'h9);
    chk("same_cyc_flags", {30'd0, vld, ovr}, 32'h2);
    idle(1'b1);

    // sync with en mid-frame restarts the frame
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sync_novld", 32'(vld), 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sync_q", 32'(q), 32'h9);
    chk("sync_vld", 32'(vld), 32'h1);
    idle(1'b1);

    // sync without en clears the count
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sync_noen_busy", 32'(busy), 32'h0);

    // Reset mid-frame, then a clean frame
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("midrst_all0", {q, vld, busy, ovr}, 32'h0);
    send_frame(4'b0110, 1'b0);
    chk("midrst_q", 32'(q), 32'h6);
    chk("midrst_vld", 32'(vld), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_jk_rx.md
SIPO_JK_RX -- requirements
Module: sipo_jk_rx

Interface
REQ-001 Parameter WIDTH, default 4: bits per frame and width of the parallel word; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 res  input  1  reset, synchronous, active-low; sampled only on the rising edge of clk.
REQ-004 sin  input  1  serial data bit, MSB of each frame first.
REQ-005 en  input  1  serial bit strobe; sin is taken only in cycles where en=1.
REQ-006 sync  input  1  frame-align; discards any partial frame, and the current bit starts a new frame.
REQ-007 rdy  input  1  consumer ready; a word is consumed in any cycle with vld=1 and rdy=1.
REQ-008 q  output  WIDTH  parallel word, held stable while vld=1.
REQ-009 vld  output  1  q holds an unconsumed word.
REQ-010 busy  output  1  partial frame in progress: bit count non-zero.
REQ-011 ovr  output  1  sticky overrun flag.

Function
REQ-012 Internal state SHALL be a WIDTH-bit shift register sr and a bit counter cnt (0..WIDTH-1).
REQ-013 en=1, sync=0, cnt<WIDTH-1: sr <= {sr[WIDTH-2:0], sin}; cnt <= cnt+1.
REQ-014 en=1, sync=0, cnt=WIDTH-1 (frame complete): assembled word W = {sr[WIDTH-2:0], sin}; cnt <= 0.
REQ-015 On frame complete with vld=0, or with vld=1 and rdy=1 in the same cycle: q <= W and vld <= 1 in the next cycle; latency is 1 clk from the last bit's edge to vld=1.
REQ-016 On frame complete with vld=1 and rdy=0: W is dropped, q and vld are unchanged, and ovr <= 1.
REQ-017 vld=1, rdy=1, no frame complete: vld <= 0 next cycle; q retains its last value.
REQ-018 en=0: sr and cnt hold; sin is ignored.
REQ-019 sync=1, en=1: sr <= {sr[WIDTH-2:0], sin}; cnt <= 1, so sin is the MSB of a new frame; no frame-complete event occurs.
REQ-020 sync=1, en=0: cnt <= 0; sr holds.
REQ-021 sync does not affect q, vld, or ovr.
REQ-022 busy SHALL be combinational (cnt != 0).
REQ-023 ovr, once set, remains 1 until reset.
REQ-024 The rdy handshake operates independently of en, so a word may be consumed in the same cycle serial bits arrive.
REQ-025 Bit order SHALL match the team's PISO transmitter: the first received bit lands in q[WIDTH-1] and the last in q[0].

Reset
REQ-026 res=0 at a rising clk edge: sr=0, cnt=0, q=0, vld=0, ovr=0, busy=0.
REQ-027 Reset has priority over en, sync, and rdy.
REQ-028 Reset mid-frame discards the partial frame; the first en=1 after res=1 is the MSB of a new frame.
REQ-029 Outputs are undefined only before the first clocked reset.

Verification (WIDTH=4)
REQ-030 Reset; en=1 for 4 cycles with sin=1,0,1,1 -> vld=1 one cycle after the 4th bit, q=4'b1011, busy=0; rdy=1 for one cycle -> vld=0 and q stays 4'b1011.
REQ-031 Bits 1,1,0,0 with en toggled 1,0,1,0,1,0,1 (sin ignored when en=0) -> q=4'b1100; busy=1 during the gaps.
REQ-032 rdy=0; frame 4'b0101, then frame 4'b1110 -> q stays 4'b0101, vld=1, ovr=1; ovr stays 1 after rdy=1 and until reset.
REQ-033 Frame 4'b0011 with vld held, then rdy=1 in the same cycle as the last bit of frame 4'b1001 -> next cycle q=4'b1001, vld=1, ovr=0.
REQ-034 Send 2 bits, then sync=1 with en=1 and sin=1, followed by 3 bits 0,0,1 -> q=4'b1001; the earlier 2 bits are discarded.
REQ-035 res=0 after 3 bits of a frame, then a full frame 4'b0110 -> q=4'b0110, and all outputs are 0 during reset.
